psum_gbf_bank_sched: RTL and testbench

Ping-pong scheduler for the two psum global-buffer banks fed by the spatial-unrolling accumulator. It gates accumulator writes into the bank currently being filled and counts irrelevant-loop passes per bank. It hands full banks to a drain read engine and frees each bank once it is drained. The accumulator is back-pressured whenever its target bank is not writable.

---
 rtl/psum_gbf_bank_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_psum_gbf_bank_sched.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_gbf_bank_sched.sv
// Ping-pong scheduler for the two psum global-buffer banks.
// The accumulator fills one bank while the drain engine empties the other.
// Each bank runs FREE -> FILLING -> FULL -> DRAINING -> FREE.
// The accumulator is stalled whenever its target bank is not the filling bank.
module psum_gbf_bank_sched #(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int PASS_BITWIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  input  logic [GBF_ADDR_BITWIDTH:0]   cfg_rel_num,
  input  logic [PASS_BITWIDTH-1:0]     cfg_irrel_num,
  input  logic                         start,
  input  logic                         conv_finish,
  input  logic                         acc_w_en,
  input  logic                         acc_w_num,
  input  logic [GBF_ADDR_BITWIDTH-1:0] acc_w_addr,
  input  logic [GBF_DATA_BITWIDTH-1:0] acc_data,
  input  logic                         acc_pass_done,
  output logic                         acc_stall,
  output logic [1:0]                   bank_w_en,
  output logic [GBF_ADDR_BITWIDTH-1:0] bank_w_addr,
  output logic [GBF_DATA_BITWIDTH-1:0] bank_w_data,
  output logic                         bank_first_pass,
  output logic                         rd_valid,
  output logic                         rd_bank,
  output logic [GBF_ADDR_BITWIDTH-1:0] rd_addr,
  input  logic                         rd_ready,
  output logic                         done,
  output logic                         err
);

  localparam int REL_W = GBF_ADDR_BITWIDTH + 1;

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_FLUSH, G_DONE} glb_state_t;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_DRAINING} bank_state_t;

  glb_state_t                   g_q, g_d;
  bank_state_t                  bank_q [2];
  bank_state_t                  bank_d [2];
  logic [PASS_BITWIDTH-1:0]     pass_q [2];
  logic [PASS_BITWIDTH-1:0]     pass_d [2];
  logic [REL_W-1:0]             rel_q, rel_d;
  logic [PASS_BITWIDTH-1:0]     irrel_q, irrel_d;
  logic                         older_q, older_d;   // bank that became FULL first
  logic                         drain_q, drain_d;   // drain engine busy (== rd_valid)
  logic                         rd_bank_q, rd_bank_d;
  logic [GBF_ADDR_BITWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                         err_q, err_d;
  logic [1:0]                   w_en_q, w_en_d;
  logic [GBF_ADDR_BITWIDTH-1:0] w_addr_q, w_addr_d;
  logic [GBF_DATA_BITWIDTH-1:0] w_data_q, w_data_d;
  logic                         first_q, first_d;

  logic                         any_fill, fill_idx, other_idx, fill_done;
  logic [PASS_BITWIDTH-1:0]     fill_cnt;
  logic                         drain_last, sel, cand;

  assign any_fill  = (bank_q[0] == B_FILLING) || (bank_q[1] == B_FILLING);
  assign fill_idx  = (bank_q[1] == B_FILLING);
  assign other_idx = ~fill_idx;
  assign fill_cnt  = pass_q[fill_idx] + PASS_BITWIDTH'(acc_pass_done);
  assign drain_last = ({1'b0, rd_addr_q} == (rel_q - REL_W'(1)));

  // Writable only while running and the addressed bank is the one being filled.
  assign acc_stall = !((g_q == G_RUN) && (bank_q[acc_w_num] == B_FILLING));

  assign bank_w_en       = w_en_q;
  assign bank_w_addr     = w_addr_q;
  assign bank_w_data     = w_data_q;
  assign bank_first_pass = first_q;
  assign rd_valid        = drain_q;
  assign rd_bank         = rd_bank_q;
  assign rd_addr         = rd_addr_q;
  assign done            = (g_q == G_DONE);
  assign err             = err_q;

  // Next-state logic for the global FSM, both bank FSMs, drain engine and write path.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    g_d       = g_q;
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    pass_d[0] = pass_q[0];
    pass_d[1] = pass_q[1];
    rel_d     = rel_q;
    irrel_d   = irrel_q;
    older_d   = older_q;
    drain_d   = drain_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    err_d     = err_q;
    w_en_d    = 2'b00;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    first_d   = first_q;
    fill_done = 1'b0;
    sel       = 1'b0;
    cand      = 1'b0;

    // Accumulator write path: stalled writes vanish silently, out-of-range ones flag err.
    if (acc_w_en && !acc_stall) begin
      if ({1'b0, acc_w_addr} < rel_q) begin
        w_en_d[acc_w_num] = 1'b1;
        w_addr_d          = acc_w_addr;
        w_data_d          = acc_data;
        first_d           = (pass_q[acc_w_num] == '0);
      end else begin
        err_d = 1'b1;
      end
    end

    // Pass accounting; conv_finish closes a partially filled bank early.
    if (any_fill) begin
      if ((g_q == G_RUN) && conv_finish) begin
        bank_d[fill_idx] = (fill_cnt != '0) ? B_FULL : B_FREE;
        pass_d[fill_idx] = '0;
        if ((fill_cnt != '0) && (bank_q[other_idx] != B_FULL)) older_d = fill_idx;
      end else if (acc_pass_done) begin
        if (fill_cnt == irrel_q) begin
          bank_d[fill_idx] = B_FULL;
          pass_d[fill_idx] = '0;
          fill_done        = 1'b1;
          if (bank_q[other_idx] != B_FULL) older_d = fill_idx;
        end else begin
          pass_d[fill_idx] = fill_cnt;
        end
      end
    end else if (acc_pass_done) begin
      err_d = 1'b1;
    end

    // Drain engine: one bank at a time, oldest FULL bank first.
    if (drain_q) begin
      if (rd_ready) begin
        if (drain_last) begin
          bank_d[rd_bank_q] = B_FREE;
          drain_d           = 1'b0;
          rd_addr_d         = '0;
        end else begin
          rd_addr_d = rd_addr_q + GBF_ADDR_BITWIDTH'(1);
        end
      end
    end else if ((bank_q[0] == B_FULL) || (bank_q[1] == B_FULL)) begin
      sel         = ((bank_q[0] == B_FULL) && (bank_q[1] == B_FULL)) ? older_q
                                                                      : (bank_q[1] == B_FULL);
      bank_d[sel] = B_DRAINING;
      drain_d     = 1'b1;
      rd_bank_d   = sel;
      rd_addr_d   = '0;
    end

    // Refill: when nothing will be filling after this edge, claim a free bank,
    // including one freed by the drain engine on this same edge.
    if ((g_q == G_RUN) && !conv_finish && (fill_done || !any_fill)) begin
      cand = fill_done ? other_idx : (bank_d[0] != B_FREE);
      if (bank_d[cand] == B_FREE) bank_d[cand] = B_FILLING;
    end

    // Global FSM.
    case (g_q)
      G_IDLE: begin
        if (cfg_valid) begin
          rel_d   = cfg_rel_num;
          irrel_d = cfg_irrel_num;
        end
        if (start) begin
          if ((rel_q != '0) && (irrel_q != '0)) begin
            g_d       = G_RUN;
            bank_d[0] = B_FILLING;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      G_RUN:   if (conv_finish) g_d = G_FLUSH;
      G_FLUSH: if ((bank_q[0] == B_FREE) && (bank_q[1] == B_FREE) && !drain_q) g_d = G_DONE;
      G_DONE: begin
        if (start) begin
          g_d       = G_RUN;
          bank_d[0] = B_FILLING;
        end
      end
      default: g_d = G_IDLE;
    endcase
  end

  // State registers; reset aborts any fill or drain in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_q       <= G_IDLE;
      bank_q[0] <= B_FREE;
      bank_q[1] <= B_FREE;
      pass_q[0] <= '0;
      pass_q[1] <= '0;
      rel_q     <= '0;
      irrel_q   <= '0;
      older_q   <= 1'b0;
      drain_q   <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      err_q     <= 1'b0;
      w_en_q    <= 2'b00;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      first_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      g_q       <= g_d;
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      pass_q[0] <= pass_d[0];
      pass_q[1] <= pass_d[1];
      rel_q     <= rel_d;
      irrel_q   <= irrel_d;
      older_q   <= older_d;
      drain_q   <= drain_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      err_q     <= err_d;
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      first_q   <= first_d;
    end
  end

endmodule

// File: tb/tb_psum_gbf_bank_sched.sv
// Self-checking bench for psum_gbf_bank_sched: expected writes and drain beats
// are queued as stimulus is driven and compared when the DUT emits them.
module tb_psum_gbf_bank_sched;

  localparam int DW = 512;
  localparam int AW = 5;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_valid, start, conv_finish, acc_w_en, acc_w_num, acc_pass_done, rd_ready;
  logic [AW:0]   cfg_rel_num;
  logic [PW-1:0] cfg_irrel_num;
  logic [AW-1:0] acc_w_addr;
  logic [DW-1:0] acc_data;
  logic          acc_stall, bank_first_pass, rd_valid, rd_bank, done, err;
  logic [1:0]    bank_w_en;
  logic [AW-1:0] bank_w_addr, rd_addr;
  logic [DW-1:0] bank_w_data;

  psum_gbf_bank_sched #(.GBF_DATA_BITWIDTH(DW), .GBF_ADDR_BITWIDTH(AW), .PASS_BITWIDTH(PW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_rel_num(cfg_rel_num),
    .cfg_irrel_num(cfg_irrel_num), .start(start), .conv_finish(conv_finish),
    .acc_w_en(acc_w_en), .acc_w_num(acc_w_num), .acc_w_addr(acc_w_addr), .acc_data(acc_data),
    .acc_pass_done(acc_pass_done), .acc_stall(acc_stall), .bank_w_en(bank_w_en),
    .bank_w_addr(bank_w_addr), .bank_w_data(bank_w_data), .bank_first_pass(bank_first_pass),
    .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic bank; logic [AW-1:0] addr; logic [DW-1:0] data; logic first; } wr_t;
  typedef struct { logic bank; logic [AW-1:0] addr; } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  wr_t ew;
  rd_t er;
  int  tests = 0;
  int  fails = 0;

  // Scoreboard: compare every emitted write and accepted drain beat against the queues.
  always @(negedge clk) begin
    if (reset) begin
      if (bank_w_en != 2'b00) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: got en=%b addr=%0d, expected no write", bank_w_en, bank_w_addr);
        end else begin
          ew = wq.pop_front();
          if (bank_w_en !== (ew.bank ? 2'b10 : 2'b01) || bank_w_addr !== ew.addr ||
              bank_w_data !== ew.data || bank_first_pass !== ew.first) begin
            fails++;
            $display("FAIL wr_scoreboard: got en=%b addr=%0d first=%b data_ok=%0b, expected bank=%0d addr=%0d first=%b",
                     bank_w_en, bank_w_addr, bank_first_pass, bank_w_data === ew.data, ew.bank, ew.addr, ew.first);
          end
        end
      end
      if (rd_valid && rd_ready) begin
        tests++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL rd_unexpected: got bank=%0d addr=%0d, expected no beat", rd_bank, rd_addr);
        end else begin
          er = rq.pop_front();
          if (rd_bank !== er.bank || rd_addr !== er.addr) begin
            fails++;
            $display("FAIL rd_scoreboard: got bank=%0d addr=%0d, expected bank=%0d addr=%0d",
                     rd_bank, rd_addr, er.bank, er.addr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_valid = 0; cfg_rel_num = '0; cfg_irrel_num = '0; start = 0; conv_finish = 0;
    acc_w_en = 0; acc_w_num = 0; acc_w_addr = '0; acc_data = '0; acc_pass_done = 0; rd_ready = 0;
  endtask

  task automatic apply_reset();
    reset = 0;
    clear_inputs();
    wq.delete();
    rq.delete();
    cyc(2);
    reset = 1;
    cyc(1);
  endtask

  task automatic configure(input int rel, input int irrel);
    cfg_valid = 1; cfg_rel_num = (AW+1)'(rel); cfg_irrel_num = PW'(irrel);
    cyc();
    cfg_valid = 0; start = 1;
    cyc();
    start = 0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // One full pass: rel writes to a bank, then a pass_done pulse.
  task automatic write_pass(input logic bank, input int rel, input logic first);
    logic [DW-1:0] d;
    for (int a = 0; a < rel; a++) begin
      d = rand_data();
      acc_w_en = 1; acc_w_num = bank; acc_w_addr = AW'(a); acc_data = d;
      wq.push_back('{bank, AW'(a), d, first});
      cyc();
      tests++;
      if (bank_w_en !== (bank ? 2'b10 : 2'b01) || bank_w_addr !== AW'(a)) begin
        fails++;
        $display("FAIL wr_latency: got en=%b addr=%0d one cycle after write, expected bank=%0d addr=%0d",
                 bank_w_en, bank_w_addr, bank, a);
      end
    end
    acc_w_en = 0; acc_pass_done = 1;
    cyc();
    acc_pass_done = 0;
  endtask

  task automatic push_drain(input logic bank, input int rel);
    for (int a = 0; a < rel; a++) rq.push_back('{bank, AW'(a)});
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n = 0;
    while ((rq.size() != 0 || rd_valid) && n < budget) begin
      cyc();
      n++;
    end
    tests++;
    if (rq.size() != 0 || rd_valid) begin
      fails++;
      $display("FAIL %s_timeout: got %0d beats outstanding rd_valid=%b, expected 0 and 0", name, rq.size(), rd_valid);
    end
  endtask

  task automatic check_stall(input logic bank, input logic exp, input string name);
    acc_w_num = bank;
    #1;
    tests++;
    if (acc_stall !== exp) begin
      fails++;
      $display("FAIL %s: got acc_stall=%b for bank %0d, expected %b", name, acc_stall, bank, exp);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    #1;
    tests++;
    if ({acc_stall, bank_w_en, rd_valid, done, err, bank_first_pass} !== 7'b1000000 ||
        rd_addr !== '0 || bank_w_addr !== '0 || bank_w_data !== '0) begin
      fails++;
      $display("FAIL reset_during: got stall=%b en=%b rdv=%b done=%b err=%b first=%b, expected 1 00 0 0 0 0",
               acc_stall, bank_w_en, rd_valid, done, err, bank_first_pass);
    end
    cyc(2);
    reset = 1;
    cyc(2);
    tests++;
    if ({acc_stall, bank_w_en, rd_valid, done, err} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_after: got stall=%b en=%b rdv=%b done=%b err=%b, expected 1 00 0 0 0",
               acc_stall, bank_w_en, rd_valid, done, err);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    rd_ready = 1;
    configure(4, 2);
    check_stall(0, 0, "basic_stall_b0_run");
    check_stall(1, 1, "basic_stall_b1_run");
    write_pass(0, 4, 1);
    push_drain(0, 4);
    write_pass(0, 4, 0);
    check_stall(1, 0, "basic_b1_filling");
    check_stall(0, 1, "basic_b0_full");
    tests++;
    if (rd_valid !== 0) begin
      fails++;
      $display("FAIL basic_drain_early: got rd_valid=%b, expected 0", rd_valid);
    end
    cyc();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_valid !== 1 || rd_bank !== 0 || rd_addr !== AW'(i)) begin
        fails++;
        $display("FAIL basic_drain_beat: got v=%b bank=%0d addr=%0d, expected v=1 bank=0 addr=%0d",
                 rd_valid, rd_bank, rd_addr, i);
      end
      cyc();
    end
    tests++;
    if (rd_valid !== 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL basic_drain_end: got rd_valid=%b left=%0d, expected 0 and 0", rd_valid, rq.size());
    end
  endtask

  task automatic test_both_full();
    apply_reset();
    rd_ready = 0;
    configure(4, 1);
    write_pass(0, 4, 1);
    write_pass(1, 4, 1);
    check_stall(0, 1, "both_full_stall_b0");
    check_stall(1, 1, "both_full_stall_b1");
    acc_w_en = 1; acc_w_num = 0; acc_w_addr = '0; acc_data = rand_data();
    cyc();
    acc_w_num = 1;
    cyc();
    acc_w_en = 0;
    tests++;
    if (bank_w_en !== 2'b00 || err !== 0 || rd_valid !== 1 || rd_bank !== 0 || rd_addr !== '0) begin
      fails++;
      $display("FAIL both_full_drop: got en=%b err=%b rdv=%b rd_bank=%0d rd_addr=%0d, expected 00 0 1 0 0",
               bank_w_en, err, rd_valid, rd_bank, rd_addr);
    end
    push_drain(0, 4);
    push_drain(1, 4);
    rd_ready = 1;
    wait_drained(40, "both_full_drain");
    check_stall(0, 0, "both_full_b0_refill");
    check_stall(1, 1, "both_full_b1_idle");
    write_pass(0, 4, 1);
    push_drain(0, 4);
    wait_drained(20, "both_full_refill_drain");
  endtask

  task automatic test_addr_err();
    apply_reset();
    configure(4, 2);
    acc_w_en = 1; acc_w_num = 0; acc_w_addr = AW'(4); acc_data = rand_data();
    cyc();
    acc_w_en = 0;
    tests++;
    if (bank_w_en !== 2'b00 || err !== 1) begin
      fails++;
      $display("FAIL addr_oob: got en=%b err=%b, expected 00 1", bank_w_en, err);
    end
    acc_w_en = 1; acc_w_addr = AW'(3); acc_data = rand_data();
    wq.push_back('{1'b0, AW'(3), acc_data, 1'b1});
    cyc();
    acc_w_en = 0;
    tests++;
    if (bank_w_en !== 2'b01 || bank_w_addr !== AW'(3)) begin
      fails++;
      $display("FAIL addr_edge: got en=%b addr=%0d, expected 01 3", bank_w_en, bank_w_addr);
    end
    cyc(5);
    tests++;
    if (err !== 1) begin
      fails++;
      $display("FAIL err_sticky: got err=%b, expected 1", err);
    end
    apply_reset();
    tests++;
    if (err !== 0) begin
      fails++;
      $display("FAIL err_cleared: got err=%b, expected 0", err);
    end
  endtask

  task automatic test_flush_partial();
    int n = 0;
    apply_reset();
    rd_ready = 1;
    configure(2, 3);
    write_pass(0, 2, 1);
    push_drain(0, 2);
    conv_finish = 1;
    cyc();
    conv_finish = 0;
    wait_drained(20, "flush_drain");
    while (!done && n < 10) begin
      cyc();
      n++;
    end
    tests++;
    if (done !== 1 || err !== 0) begin
      fails++;
      $display("FAIL flush_done: got done=%b err=%b, expected 1 0", done, err);
    end
    check_stall(0, 1, "flush_stall_b0");
    check_stall(1, 1, "flush_stall_b1");
    acc_w_en = 1; acc_w_num = 0; acc_w_addr = '0; acc_data = rand_data();
    cyc();
    acc_w_en = 0;
    tests++;
    if (bank_w_en !== 2'b00 || done !== 1) begin
      fails++;
      $display("FAIL flush_write_drop: got en=%b done=%b, expected 00 1", bank_w_en, done);
    end
    start = 1;
    cyc();
    start = 0;
    tests++;
    if (done !== 0) begin
      fails++;
      $display("FAIL restart_done: got done=%b, expected 0", done);
    end
    check_stall(0, 0, "restart_b0_filling");
  endtask

  task automatic test_rd_ready_toggle();
    int pat [8] = '{1, 0, 0, 1, 0, 1, 1, 1};
    int exp_addr = 0;
    int n = 0;
    apply_reset();
    rd_ready = 0;
    configure(4, 1);
    write_pass(0, 4, 1);
    while (!rd_valid && n < 10) begin
      cyc();
      n++;
    end
    push_drain(0, 4);
    for (int i = 0; i < 8 && exp_addr < 4; i++) begin
      tests++;
      if (rd_valid !== 1 || rd_bank !== 0 || rd_addr !== AW'(exp_addr)) begin
        fails++;
        $display("FAIL toggle_hold: got v=%b bank=%0d addr=%0d, expected v=1 bank=0 addr=%0d",
                 rd_valid, rd_bank, rd_addr, exp_addr);
      end
      rd_ready = (pat[i] != 0);
      cyc();
      if (pat[i] != 0) exp_addr++;
    end
    rd_ready = 0;
    tests++;
    if (rd_valid !== 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL toggle_end: got rd_valid=%b left=%0d, expected 0 and 0", rd_valid, rq.size());
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    apply_reset();
    rd_ready = 0;
    configure(4, 1);
    write_pass(0, 4, 1);
    while (!rd_valid && n < 10) begin
      cyc();
      n++;
    end
    acc_w_en = 1; acc_w_num = 1; acc_w_addr = '0; acc_data = rand_data();
    cyc();
    acc_w_en = 0;
    tests++;
    if (rd_valid !== 1 || bank_w_en !== 2'b10) begin
      fails++;
      $display("FAIL areset_pre: got rdv=%b en=%b, expected 1 10", rd_valid, bank_w_en);
    end
    #1 reset = 0;
    #1;
    tests++;
    if (rd_valid !== 0 || bank_w_en !== 2'b00 || done !== 0 || acc_stall !== 1) begin
      fails++;
      $display("FAIL areset_async: got rdv=%b en=%b done=%b stall=%b, expected 0 00 0 1",
               rd_valid, bank_w_en, done, acc_stall);
    end
    wq.delete();
    rq.delete();
    cyc(2);
    reset = 1;
    cyc(2);
    tests++;
    if (rd_valid !== 0 || acc_stall !== 1 || err !== 0) begin
      fails++;
      $display("FAIL areset_idle: got rdv=%b stall=%b err=%b, expected 0 1 0", rd_valid, acc_stall, err);
    end
    start = 1;
    cyc();
    start = 0;
    tests++;
    if (err !== 1 || acc_stall !== 1) begin
      fails++;
      $display("FAIL start_no_cfg: got err=%b stall=%b, expected 1 1", err, acc_stall);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_both_full();
    test_addr_err();
    test_flush_partial();
    test_rd_ready_toggle();
    test_async_reset();
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
